alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the 11-opcode encoding, adds shifts, an iterative unsigned multiply and an internal accumulator, and registers every result with a zero flag. Valid/ready handshakes on input and output let it sit between a decode stage and a writeback stage, with back-pressure in both directions.

## Interface
- `WIDTH`, default 8: operand width; results are `WIDTH+1` bits.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `a  in  WIDTH`: operand A.
- `b  in  WIDTH`: operand B.
- `op  in  4`: opcode, listed under Operation.
- `in_valid  in  1`: `a`, `b` and `op` are valid.
- `in_ready  out  1`: block can accept an operation this cycle.
- `alu_out  out  WIDTH+1`: registered result.
- `zero  out  1`: registered; 1 when `alu_out[WIDTH-1:0] == 0`.
- `out_valid  out  1`: `alu_out` and `zero` are valid.
- `out_ready  in  1`: consumer accepts the result.

## Operation
- Opcodes. Operands are zero-extended to `WIDTH+1` bits unless stated otherwise:
  - 0000 ZERO: 0
  - 0001 ADD: a+b; carry lands in bit WIDTH
  - 0010 SUB: a-b mod 2^(WIDTH+1); bit WIDTH = borrow
  - 0011 AND, 0100 OR, 0101 NOTA, 0110 NOTB, 0111 XOR, 1000 NOR, 1001 XNOR
  - 1010 MAX: larger of a and b, unsigned
  - 1011 SHL: {a, 1'b0}; bit WIDTH = a[WIDTH-1]
  - 1100 SHR: {a[0], 1'b0, a[WIDTH-1:1]}; bit WIDTH = shifted-out bit
  - 1101 MUL: unsigned a*b, low WIDTH bits; bit WIDTH = 1 if product >= 2^WIDTH
  - 1110 ACC: acc <= acc+a, mod 2^WIDTH; result is {carry, new acc}
  - 1111 ACLR: acc <= 0; result 0
- Logic ops (0011–1001) and MAX always force bit WIDTH to 0.
- `acc` is a WIDTH-bit register. It changes only on ACC and ACLR.
- State machine (IDLE, MUL, HOLD):
  - IDLE: `in_ready=1`. On accept, a non-MUL op writes the result and goes to HOLD. MUL latches the operands, clears the product and count, and goes to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles. After the last step, it writes the result and goes to HOLD. `in_ready=0`.
  - HOLD: `out_valid=1`; `alu_out` is stable. When `out_ready=1`, the result retires.
    - If `in_valid=1` in the same cycle, the new op is accepted (`in_ready = out_ready`) and handled exactly as from IDLE.
    - Otherwise, go to IDLE.
- Accept condition: `in_valid & in_ready`. The block samples operands only on accept.

## Timing
- Reset values: `alu_out=0`, `zero=0`, `out_valid=0`, `acc=0`, state IDLE. `in_ready` is 1 in the first cycle after reset deasserts.
- Non-MUL latency: accepted at edge N, `out_valid=1` after edge N+1.
- MUL latency: accepted at edge N, `out_valid=1` after edge N+1+WIDTH.
- Throughput: one non-MUL op per cycle while `out_ready` stays high.
- `out_ready=0` in HOLD: result held indefinitely and `in_ready=0`; no op is lost or overwritten.
- `out_ready` outside HOLD is ignored.
- `rst` in any state, including mid-MUL, aborts the op. The partial product is discarded and all reset values apply on the next edge; `acc` is cleared.
- ACC that follows ACC back-to-back uses the accumulator value just written, with no hazard.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams `OP_ZERO`…`OP_ACLR`
  - state enum `alu_state_t` {`S_IDLE`, `S_MUL`, `S_HOLD`}
- Sub-module `alu_mul_iter` (parameter WIDTH):
  - ports: clk, rst, start, a, b, done, product[2*WIDTH-1:0]
  - shift-add, WIDTH cycles; `done` is a one-cycle pulse
- Top level holds the FSM, combinational result mux, accumulator and output registers.

## Test plan
- Reset, then ADD a=8'hFF b=8'h01 with `out_ready=1` -> one cycle later `alu_out=9'h100`, `zero=1`, `out_valid=1`.
- SUB a=3 b=5 -> `alu_out=9'h1FE`. NOTA a=8'h0F -> `alu_out=9'h0F0`, bit 8 = 0.
- MUL a=8'h10 b=8'h10, WIDTH=8 -> `out_valid` rises 9 cycles after accept, `alu_out=9'h100`. MUL 12*11 -> `alu_out=9'h084`; `in_ready=0` throughout.
- ACLR, then ACC a=200, then ACC a=100 -> results 0, 9'h0C8, 9'h12C (acc=44).
- Hold `out_ready=0` for 5 cycles after ADD -> `alu_out` stable, `in_ready=0`. Then raise `out_ready` with a new op valid -> it is accepted the same cycle.
- Assert `rst` 3 cycles into MUL -> next cycle `out_valid=0`, `alu_out=0`, state IDLE. A following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the sequential ALU.
package alu_pkg;
  localparam logic [3:0] OP_ZERO = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOTA = 4'h5;
  localparam logic [3:0] OP_NOTB = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_MAX  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_ACC  = 4'hE;
  localparam logic [3:0] OP_ACLR = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} alu_state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: WIDTH steps after start, then a one-cycle done pulse.
// No backpressure; start restarts it, rst aborts it.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_prod   <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        // done rises with the final partial product already in r_prod
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_prod;
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with accumulator and registered result/zero flag; 1-cycle latency, WIDTH+1 for MUL.
// Result is held while out_ready is low; in_ready follows out_ready in HOLD, so nothing is overwritten.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   alu_out,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);
  alu_state_t         r_state, w_state_nxt;
  logic               w_in_rdy, w_out_vld, w_accept;
  logic               w_load_alu, w_load_mul, w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_res, w_mul_res, w_acc_sum;
  logic [WIDTH:0]     r_out;
  logic               r_zero;
  logic [WIDTH-1:0]   r_acc;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    w_load_mul  = 1'b0;
    w_load_alu  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      S_IDLE: w_in_rdy = 1'b1;
      S_MUL: begin
        if (w_mul_done) begin
          w_load_mul  = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_out_vld = 1'b1;
        w_in_rdy  = out_ready;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // an accept in HOLD overrides the retire-to-IDLE above
    w_accept = in_valid & w_in_rdy;
    if (w_accept) begin
      if (op == OP_MUL) begin
        w_mul_start = 1'b1;
        w_state_nxt = S_MUL;
      end else begin
        w_load_alu  = 1'b1;
        w_state_nxt = S_HOLD;
      end
    end
  end

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, a};
  assign w_mul_res = {|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1:0]};

  always_comb begin
    w_res = '0;
    case (op)
      OP_ADD:  w_res = {1'b0, a} + {1'b0, b};
      OP_SUB:  w_res = {1'b0, a} - {1'b0, b};
      OP_AND:  w_res = {1'b0, a & b};
      OP_OR:   w_res = {1'b0, a | b};
      OP_NOTA: w_res = {1'b0, ~a};
      OP_NOTB: w_res = {1'b0, ~b};
      OP_XOR:  w_res = {1'b0, a ^ b};
      OP_NOR:  w_res = {1'b0, ~(a | b)};
      OP_XNOR: w_res = {1'b0, ~(a ^ b)};
      OP_MAX:  w_res = (a > b) ? {1'b0, a} : {1'b0, b};
      OP_SHL:  w_res = {a, 1'b0};
      OP_SHR:  w_res = {a[0], 1'b0, a[WIDTH-1:1]};
      OP_ACC:  w_res = w_acc_sum;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_zero <= 1'b0;
      r_acc  <= '0;
    end else if (w_load_alu) begin
      r_out  <= w_res;
      r_zero <= (w_res[WIDTH-1:0] == '0);
      if (op == OP_ACC)       r_acc <= w_acc_sum[WIDTH-1:0];
      else if (op == OP_ACLR) r_acc <= '0;
    end else if (w_load_mul) begin
      r_out  <= w_mul_res;
      r_zero <= (w_mul_res[WIDTH-1:0] == '0);
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = w_out_vld;
  assign alu_out   = r_out;
  assign zero      = r_zero;
endmodule

// File: tb/tb_alu_seq.sv
// Directed, self-checking bench for alu_seq (WIDTH=8) with hand-computed expected values.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] op;
  logic       in_valid, in_ready, out_valid, out_ready, zero;
  logic [8:0] alu_out;
  int         n_cmp = 0;
  int         n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = OP_ZERO;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (alu_out !== 9'h000) begin n_err++; $display("FAIL reset_alu_out got=%h want=000", alu_out); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b want=0", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add();
    op = OP_ADD; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_out_valid got=%b want=1", out_valid); end
    n_cmp++; if (alu_out !== 9'h100) begin n_err++; $display("FAIL add_alu_out got=%h want=100", alu_out); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL add_zero got=%b want=1", zero); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_retire got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t_op [7];
    logic [7:0] t_a  [7];
    logic [7:0] t_b  [7];
    logic [8:0] t_exp[7];
    t_op[0] = OP_SUB;  t_a[0] = 8'h03; t_b[0] = 8'h05; t_exp[0] = 9'h1FE;
    t_op[1] = OP_NOTA; t_a[1] = 8'h0F; t_b[1] = 8'h33; t_exp[1] = 9'h0F0;
    t_op[2] = OP_XOR;  t_a[2] = 8'hA5; t_b[2] = 8'h0F; t_exp[2] = 9'h0AA;
    t_op[3] = OP_MAX;  t_a[3] = 8'h30; t_b[3] = 8'hC0; t_exp[3] = 9'h0C0;
    t_op[4] = OP_SHL;  t_a[4] = 8'h81; t_b[4] = 8'h00; t_exp[4] = 9'h102;
    t_op[5] = OP_SHR;  t_a[5] = 8'h81; t_b[5] = 8'h00; t_exp[5] = 9'h140;
    t_op[6] = OP_NOR;  t_a[6] = 8'hF0; t_b[6] = 8'h0F; t_exp[6] = 9'h000;
    for (int i = 0; i < 7; i++) begin
      op = t_op[i]; a = t_a[i]; b = t_b[i]; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid[%0d] got=%b want=1", i, out_valid); end
      n_cmp++; if (alu_out !== t_exp[i]) begin n_err++; $display("FAIL b2b_alu_out[%0d] got=%h want=%h", i, alu_out, t_exp[i]); end
      n_cmp++; if (zero !== (t_exp[i][7:0] == 8'h00)) begin n_err++; $display("FAIL b2b_zero[%0d] got=%b want=%b", i, zero, t_exp[i][7:0] == 8'h00); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input logic [8:0] exp, input string nm);
    int cyc = 0;
    int rdy_hi = 0;
    op = OP_MUL; a = ma; b = mb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 8'h5A; b = 8'hA5;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0) rdy_hi++;
      tick();
      cyc++;
    end
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL %s_latency got=%0d want=9", nm, cyc); end
    n_cmp++; if (rdy_hi != 0) begin n_err++; $display("FAIL %s_in_ready_busy got=%0d high cycles want=0", nm, rdy_hi); end
    n_cmp++; if (alu_out !== exp) begin n_err++; $display("FAIL %s_alu_out got=%h want=%h", nm, alu_out, exp); end
  endtask

  task automatic test_mul();
    run_mul(8'h10, 8'h10, 9'h100, "mul_16x16");
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL mul_zero got=%b want=1", zero); end
    run_mul(8'd12, 8'd11, 9'h084, "mul_12x11");
    tick();
  endtask

  task automatic test_acc();
    logic [3:0] t_op [4];
    logic [7:0] t_a  [4];
    logic [8:0] t_exp[4];
    t_op[0] = OP_ACLR; t_a[0] = 8'd77;  t_exp[0] = 9'h000;
    t_op[1] = OP_ACC;  t_a[1] = 8'd200; t_exp[1] = 9'h0C8;
    t_op[2] = OP_ACC;  t_a[2] = 8'd100; t_exp[2] = 9'h12C;
    t_op[3] = OP_ACC;  t_a[3] = 8'd0;   t_exp[3] = 9'h02C;
    b = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      op = t_op[i]; a = t_a[i]; in_valid = 1'b1;
      tick();
      n_cmp++; if (alu_out !== t_exp[i]) begin n_err++; $display("FAIL acc_alu_out[%0d] got=%h want=%h", i, alu_out, t_exp[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    int bad = 0;
    out_ready = 1'b0;
    op = OP_ADD; a = 8'd2; b = 8'd3; in_valid = 1'b1;
    tick();
    a = 8'd7; b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      if (alu_out !== 9'h005 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      tick();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
    n_cmp++; if (alu_out !== 9'h005) begin n_err++; $display("FAIL hold_alu_out got=%h want=005", alu_out); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (alu_out !== 9'h008) begin n_err++; $display("FAIL hold_next_op got=%h want=008", alu_out); end
    tick();
  endtask

  task automatic test_rst_mul();
    int late = 0;
    op = OP_MUL; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmul_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (alu_out !== 9'h000) begin n_err++; $display("FAIL rstmul_alu_out got=%h want=000", alu_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmul_idle got=%b want=1", in_ready); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) late++;
      tick();
    end
    n_cmp++; if (late != 0) begin n_err++; $display("FAIL rstmul_stale_done got=%0d want=0", late); end
    op = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    tick();
    n_cmp++; if (alu_out !== 9'h002) begin n_err++; $display("FAIL rstmul_add got=%h want=002", alu_out); end
    op = OP_ACC; a = 8'd0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (alu_out !== 9'h000) begin n_err++; $display("FAIL rstmul_acc_cleared got=%h want=000", alu_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_acc();
    test_hold();
    test_rst_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
